// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: redirect/control inputs from decode and PC/status outputs.
interface pc_fetch_unit_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        jalr;
   logic [31:0] jalr_base;
   logic [31:0] jalr_imm;
   logic        halt;
   logic        resume;
   logic [31:0] Address;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        misalign_trap;
   logic [31:0] trap_pc;
   logic [1:0]  state;
   logic [31:0] cycle_count;
   logic [31:0] instret_count;

   // Fetch unit side
   modport master (
      input  stall, branch_taken, branch_target, jump, jump_target,
      input  jalr, jalr_base, jalr_imm, halt, resume,
      output Address, pc_plus4, fetch_valid, misalign_trap, trap_pc,
      output state, cycle_count, instret_count
   );

   // Decode / environment side
   modport slave (
      output stall, branch_taken, branch_target, jump, jump_target,
      output jalr, jalr_base, jalr_imm, halt, resume,
      input  Address, pc_plus4, fetch_valid, misalign_trap, trap_pc,
      input  state, cycle_count, instret_count
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and next-PC selection for the single-cycle core, with stall,
// halt/resume, misaligned-target trap and cycle/instret counters.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input logic              clk,
   input logic              rstn,
   pc_fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {
      StBoot   = 2'b00,
      StRun    = 2'b01,
      StHalt   = 2'b10,
      StUnused = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] trap_pc_q, trap_pc_d;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] instret_q, instret_d;
   logic        misalign_q, misalign_d;

   logic [31:0] addr;
   logic [31:0] seq_pc;
   logic [31:0] jalr_target;
   logic [31:0] run_pc;
   logic        run_misaligned;

   // BOOT (and the unused encoding) always presents the reset vector
   assign addr        = (state_q == StRun || state_q == StHalt) ? pc_q : RESET_VECTOR;
   assign seq_pc      = addr + 32'd4;
   assign jalr_target = (bus.jalr_base + bus.jalr_imm) & ~32'd1;

   // Redirect priority and alignment check for a non-stalled, non-halting RUN cycle
   always_comb begin
      run_pc         = seq_pc;
      run_misaligned = 1'b0;
      if (bus.jalr) begin
         run_pc         = jalr_target;
         run_misaligned = jalr_target[1];
      end else if (bus.jump) begin
         run_pc         = bus.jump_target;
         run_misaligned = (bus.jump_target[1:0] != 2'b00);
      end else if (bus.branch_taken) begin
         run_pc         = bus.branch_target;
         run_misaligned = (bus.branch_target[1:0] != 2'b00);
      end
   end

   // Next-state, next-PC, trap and counter updates
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      trap_pc_d  = trap_pc_q;
      cycle_d    = cycle_q;
      instret_d  = instret_q;
      misalign_d = 1'b0;
      case (state_q)
         StRun: begin
            cycle_d = cycle_q + 32'd1;
            if (!bus.stall) begin
               instret_d = instret_q + 32'd1;
               if (bus.halt) begin
                  pc_d    = seq_pc;
                  state_d = StHalt;
               end else if (run_misaligned) begin
                  pc_d       = TRAP_VECTOR;
                  trap_pc_d  = addr;
                  misalign_d = 1'b1;
               end else begin
                  pc_d = run_pc;
               end
            end
         end
         StHalt: begin
            if (bus.resume) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StRun;
            pc_d    = RESET_VECTOR;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VECTOR;
         trap_pc_q  <= 32'd0;
         cycle_q    <= 32'd0;
         instret_q  <= 32'd0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         trap_pc_q  <= trap_pc_d;
         cycle_q    <= cycle_d;
         instret_q  <= instret_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.Address       = addr;
   assign bus.pc_plus4      = seq_pc;
   assign bus.fetch_valid   = (state_q == StRun);
   assign bus.misalign_trap = misalign_q;
   assign bus.trap_pc       = trap_pc_q;
   assign bus.state         = state_q;
   assign bus.cycle_count   = cycle_q;
   assign bus.instret_count = instret_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-control stage of the single-cycle core. Sits directly upstream of the instruction memory: owns the PC register, selects the next PC from sequential, branch, JAL and JALR sources, and drives `Address` into the instruction memory every cycle. Also handles stall, halt/resume and misaligned-target traps, and keeps cycle and retired-instruction counters.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC loaded after reset.
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on a misaligned-target trap.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold PC for this cycle.
- `branch_taken`  in  1  conditional branch resolved taken.
- `branch_target`  in  32  PC-relative branch target.
- `jump`  in  1  JAL.
- `jump_target`  in  32  JAL target.
- `jalr`  in  1  JALR.
- `jalr_base`  in  32  rs1 value.
- `jalr_imm`  in  32  sign-extended immediate.
- `halt`  in  1  ECALL/EBREAK decoded.
- `resume`  in  1  leave HALT.
- `Address`  out  32  current PC to instruction memory.
- `pc_plus4`  out  32  `Address + 4` (link value), combinational.
- `fetch_valid`  out  1  `Address` holds an instruction to execute this cycle.
- `misalign_trap`  out  1  one-cycle pulse on trap entry.
- `trap_pc`  out  32  PC of the instruction that caused the last trap.
- `state`  out  2  FSM state.
- `cycle_count`  out  32  cycles spent in RUN.
- `instret_count`  out  32  instructions retired.

## Operation
- FSM states: BOOT=2'b00, RUN=2'b01, HALT=2'b10; 2'b11 unused, decodes to BOOT.
- BOOT: `Address`=RESET_VECTOR, `fetch_valid`=0; next cycle goes to RUN unconditionally.
- RUN: `fetch_valid`=1; next PC chosen by priority: stall (hold) > halt > jalr > jump > branch_taken > `Address`+4.
- JALR target = (`jalr_base` + `jalr_imm`) with bit 0 cleared; 32-bit add, carry discarded.
- Misaligned: selected redirect target with bits [1:0] != 0 (JALR: bit 1 != 0). PC <= TRAP_VECTOR, `trap_pc` <= current `Address`, `misalign_trap`=1 for exactly the cycle after the edge; stays in RUN.
- halt in RUN (not stalled): PC <= `Address`+4, go to HALT; instruction counts as retired.
- HALT: `fetch_valid`=0, PC held, counters frozen; `resume`=1 returns to RUN at the held PC next edge. Other inputs ignored.
- Sequential PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no trap.
- `cycle_count` increments every RUN cycle, including stalls. `instret_count` increments every RUN cycle without stall, including trapping cycles. Both wrap at 2^32.
- Redirect inputs presented during a stall are dropped. Decode must re-present them.

## Timing
- Reset: `rstn` sampled low at an edge gives state=BOOT, `Address`=RESET_VECTOR, `trap_pc`=0, `misalign_trap`=0, counters=0, `fetch_valid`=0. Reset mid-operation overrides everything, including an in-flight trap or HALT.
- `Address` is registered. Redirect, halt and stall are sampled at edge N; the new `Address` is visible after edge N, so redirect latency is 1 cycle.
- Instruction memory reads combinationally, so `Instruction` matches `Address` within the same cycle.
- `pc_plus4` is combinational from `Address`.
- `misalign_trap` and `trap_pc` update on the same edge as the PC load to TRAP_VECTOR.
- Multiple redirects in one cycle are illegal from decode; the priority above is still mandatory.

## Test plan
- Reset release: hold `rstn`=0 for 3 cycles then release -> one BOOT cycle with `Address`=0 and `fetch_valid`=0; then RUN with `Address` 0,4,8,12 on consecutive cycles.
- Branch/jump/jalr: at `Address`=8 assert `branch_taken` with target 0x40 -> next `Address`=0x40. Then jalr with base 0x101, imm 3 -> `Address`=0x104. With `jump`=1 and `branch_taken`=1 together -> jump target wins.
- Stall: assert `stall` 2 cycles at `Address`=0x10 with `branch_taken` active -> `Address` stays 0x10; the branch is dropped; `cycle_count`+2, `instret_count`+0.
- Misaligned: at `Address`=0x20 assert jump to 0x22 -> `Address`=0x100, `trap_pc`=0x20, one-cycle `misalign_trap` pulse.
- Halt/resume: halt at `Address`=0x30 -> HALT, `Address`=0x34, `fetch_valid`=0, counters frozen for 5 cycles; `resume` -> RUN, next `Address`=0x38.
- Wrap/reset: force PC to 0xFFFF_FFFC -> next `Address`=0 with no trap. Assert `rstn`=0 during HALT -> BOOT with all outputs at reset values.
